// File: rtl/ncc_peak_tracker_if.sv
// Handshake/result bundle between the NCC PE array, the peak tracker and feature-matching control.
// The producer drives start/score_valid/acc_in; the tracker returns status and the best match.
interface ncc_peak_tracker_if #(
  parameter int N_ROWS = 16,
  parameter int ACC_W  = 8,
  parameter int WIN_W  = 16,
  parameter int WIN_H  = 16
);
  localparam int SUM_W = ACC_W + $clog2(N_ROWS);
  localparam int XW    = (WIN_W > 1) ? $clog2(WIN_W) : 1;
  localparam int YW    = (WIN_H > 1) ? $clog2(WIN_H) : 1;

  logic                           start;
  logic                           score_valid;
  logic [N_ROWS-1:0][ACC_W-1:0]   acc_in;
  logic                           busy;
  logic                           done;
  logic signed [SUM_W-1:0]        best_score;
  logic [XW-1:0]                  best_x;
  logic [YW-1:0]                  best_y;
  logic                           found;

  modport master (
    output start, score_valid, acc_in,
    input  busy, done, best_score, best_x, best_y, found
  );

  modport slave (
    input  start, score_valid, acc_in,
    output busy, done, best_score, best_x, best_y, found
  );
endinterface

// File: rtl/ncc_peak_tracker.sv
// Sums per-row NCC accumulators into a score (2 pipeline stages) and tracks the max over the search grid.
// done rises 2 edges after the last accepted score; no backpressure, scores are accepted whenever RUN.
module ncc_peak_tracker #(
  parameter int N_ROWS = 16,
  parameter int ACC_W  = 8,
  parameter int WIN_W  = 16,
  parameter int WIN_H  = 16,
  parameter logic signed [ACC_W+$clog2(N_ROWS)-1:0] THRESH = '0
) (
  input  logic              clk,
  input  logic              rst,
  ncc_peak_tracker_if.slave bus
);
  localparam int SUM_W = ACC_W + $clog2(N_ROWS);
  localparam int PW    = ACC_W + 2;
  localparam int NG    = N_ROWS / 4;
  localparam int XW    = (WIN_W > 1) ? $clog2(WIN_W) : 1;
  localparam int YW    = (WIN_H > 1) ? $clog2(WIN_H) : 1;
  localparam logic signed [SUM_W-1:0] SCORE_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [XW-1:0]           x;
  logic [YW-1:0]           y;

  logic                    s1_vld;
  logic [NG-1:0][PW-1:0]   s1_part;
  logic [XW-1:0]           s1_x;
  logic [YW-1:0]           s1_y;

  logic                    s2_vld;
  logic signed [SUM_W-1:0] s2_total;
  logic [XW-1:0]           s2_x;
  logic [YW-1:0]           s2_y;

  logic signed [SUM_W-1:0] best_score;
  logic [XW-1:0]           best_x;
  logic [YW-1:0]           best_y;
  logic                    found;

  logic [NG-1:0][PW-1:0]   part;
  logic signed [SUM_W-1:0] total;
  logic signed [SUM_W-1:0] best_nxt;
  logic                    go, accept, last_acc, upd, drain_end;

  always_comb begin
    part = '0;
    for (int g = 0; g < NG; g++) begin
      for (int l = 0; l < 4; l++) begin
        part[g] = part[g] + PW'($signed(bus.acc_in[4*g+l]));
      end
    end
  end

  always_comb begin
    total = '0;
    for (int g = 0; g < NG; g++) begin
      total = total + SUM_W'($signed(s1_part[g]));
    end
  end

  assign go        = ((state == IDLE) || (state == DONE)) && bus.start;
  assign accept    = (state == RUN) && bus.score_valid;
  assign last_acc  = accept && (x == XW'(WIN_W - 1)) && (y == YW'(WIN_H - 1));
  // Strict compare so ties keep the earlier position.
  assign upd       = s2_vld && (s2_total > best_score);
  assign best_nxt  = upd ? s2_total : best_score;
  // Stage 1 empty in DRAIN means this edge retires the final score.
  assign drain_end = (state == DRAIN) && !s1_vld;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (go) state_nxt = RUN;
      RUN:     if (last_acc) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = DONE;
      DONE:    if (go) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      s1_vld     <= 1'b0;
      s1_part    <= '0;
      s1_x       <= '0;
      s1_y       <= '0;
      s2_vld     <= 1'b0;
      s2_total   <= '0;
      s2_x       <= '0;
      s2_y       <= '0;
      best_score <= '0;
      best_x     <= '0;
      best_y     <= '0;
      found      <= 1'b0;
    end else if (go) begin
      x          <= '0;
      y          <= '0;
      s1_vld     <= 1'b0;
      s2_vld     <= 1'b0;
      best_score <= SCORE_MIN;
      best_x     <= '0;
      best_y     <= '0;
      found      <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_part <= part;
        s1_x    <= x;
        s1_y    <= y;
        if (x == XW'(WIN_W - 1)) begin
          x <= '0;
          y <= (y == YW'(WIN_H - 1)) ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end

      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_total <= total;
        s2_x     <= s1_x;
        s2_y     <= s1_y;
      end

      if (upd) begin
        best_score <= s2_total;
        best_x     <= s2_x;
        best_y     <= s2_y;
      end

      if (drain_end) found <= (best_nxt >= THRESH);
    end
  end

  assign bus.busy       = (state == RUN) || (state == DRAIN);
  assign bus.done       = (state == DONE);
  assign bus.best_score = best_score;
  assign bus.best_x     = best_x;
  assign bus.best_y     = best_y;
  assign bus.found      = found;
endmodule
